arbitro_memoria: RTL and testbench

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

---
 rtl/arbitro_memoria.sv | 157 +++++++++++++++
 tb/tb_arbitro_memoria.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_memoria
//  Purpose  : Two-port arbiter in front of a single-ported word memory.
//             Port 0 = pipeline MEM stage, port 1 = loader/debug.
//             Round-robin or fixed priority with starvation guard for port 1.
//  Revision : 1.0 - initial release
// ============================================================================
module arbitro_memoria #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 10,
   parameter int PRIORIDAD_FIJA = 0,
   parameter int MAX_ESPERA     = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   // port 0
   input  logic              req_0,
   input  logic              we_0,
   input  logic [ADDR_W-1:0] dir_0,
   input  logic [DATA_W-1:0] din_0,
   output logic              gnt_0,
   output logic              rvalid_0,
   output logic [DATA_W-1:0] dout_0,
   // port 1
   input  logic              req_1,
   input  logic              we_1,
   input  logic [ADDR_W-1:0] dir_1,
   input  logic [DATA_W-1:0] din_1,
   output logic              gnt_1,
   output logic              rvalid_1,
   output logic [DATA_W-1:0] dout_1,
   // memory side
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_dir,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   // Counter wide enough to reach MAX_ESPERA (at least one bit).
   localparam int c_ew = (MAX_ESPERA < 1) ? 1 : $clog2(MAX_ESPERA + 1);
   localparam logic [c_ew-1:0] c_espera_max = c_ew'(MAX_ESPERA);

   logic              r_gnt_0, r_gnt_1;
   logic              r_mem_read, r_mem_write;
   logic [ADDR_W-1:0] r_mem_dir;
   logic [DATA_W-1:0] r_mem_din;
   logic              r_rvalid_0, r_rvalid_1;
   logic [DATA_W-1:0] r_dout_0, r_dout_1;
   logic              r_ultimo;
   logic [c_ew-1:0]   r_espera;

   logic              w_win_0, w_win_1;
   logic [c_ew-1:0]   w_espera_next;

   // Winner selection for the command registered at this rising edge.
   always_comb begin
      w_win_0 = 1'b0;
      w_win_1 = 1'b0;
      if (req_0 && req_1) begin
         if (PRIORIDAD_FIJA != 0) begin
            // Port 0 wins ties unless port 1 has lost MAX_ESPERA times in a row.
            if (r_espera == c_espera_max) w_win_1 = 1'b1;
            else                          w_win_0 = 1'b1;
         end else begin
            // The port not granted most recently wins.
            if (r_ultimo) w_win_0 = 1'b1;
            else          w_win_1 = 1'b1;
         end
      end else if (req_0) begin
         w_win_0 = 1'b1;
      end else if (req_1) begin
         w_win_1 = 1'b1;
      end
   end

   // Starvation counter: counts port-1 losses, saturates, clears on grant or idle.
   always_comb begin
      w_espera_next = r_espera;
      if ((PRIORIDAD_FIJA == 0) || !req_1 || w_win_1) begin
         w_espera_next = '0;
      end else if (r_espera != c_espera_max) begin
         w_espera_next = r_espera + c_ew'(1);
      end
   end

   // Register the winning command onto the memory bus and pulse its grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gnt_0     <= 1'b0;
         r_gnt_1     <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_dir   <= '0;
         r_mem_din   <= '0;
      end else begin
         r_gnt_0 <= w_win_0;
         r_gnt_1 <= w_win_1;
         if (w_win_0) begin
            r_mem_read  <= ~we_0;
            r_mem_write <= we_0;
            r_mem_dir   <= dir_0;
            r_mem_din   <= din_0;
         end else if (w_win_1) begin
            r_mem_read  <= ~we_1;
            r_mem_write <= we_1;
            r_mem_dir   <= dir_1;
            r_mem_din   <= din_1;
         end else begin
            // Idle: strobes drop, address/data hold their last values.
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
         end
      end
   end

   // Capture read data for the port whose read ran during the ending cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rvalid_0 <= 1'b0;
         r_rvalid_1 <= 1'b0;
         r_dout_0   <= '0;
         r_dout_1   <= '0;
      end else begin
         r_rvalid_0 <= r_mem_read & r_gnt_0;
         r_rvalid_1 <= r_mem_read & r_gnt_1;
         if (r_mem_read && r_gnt_0) r_dout_0 <= mem_dout;
         if (r_mem_read && r_gnt_1) r_dout_1 <= mem_dout;
      end
   end

   // Arbitration history: last winner and port-1 starvation count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ultimo <= 1'b1;
         r_espera <= '0;
      end else begin
         if (w_win_0)      r_ultimo <= 1'b0;
         else if (w_win_1) r_ultimo <= 1'b1;
         r_espera <= w_espera_next;
      end
   end

   assign gnt_0     = r_gnt_0;
   assign gnt_1     = r_gnt_1;
   assign rvalid_0  = r_rvalid_0;
   assign rvalid_1  = r_rvalid_1;
   assign dout_0    = r_dout_0;
   assign dout_1    = r_dout_1;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_dir   = r_mem_dir;
   assign mem_din   = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbitro_memoria
//  Purpose  : Directed self-checking bench for arbitro_memoria.
//             Instance a: round-robin defaults. Instance f: fixed, MAX_ESPERA=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_memoria;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   // instance a signals
   logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
   logic [9:0]  dir0 = 0, dir1 = 0;
   logic [31:0] din0 = 0, din1 = 0;
   logic        gnt0, rv0, gnt1, rv1, mrd, mwr;
   logic [31:0] dout0, dout1, mdin;
   logic [31:0] mdout = 0;
   logic [9:0]  mdir;
   // instance f signals
   logic        req0_f = 0, req1_f = 0;
   logic        gnt0_f, rv0_f, gnt1_f, rv1_f, mrd_f, mwr_f;
   logic [31:0] dout0_f, dout1_f, mdin_f;
   logic [31:0] mdout_f = 0;
   logic [9:0]  mdir_f;

   arbitro_memoria u_a (
      .clk(clk), .reset_n(reset_n),
      .req_0(req0), .we_0(we0), .dir_0(dir0), .din_0(din0),
      .gnt_0(gnt0), .rvalid_0(rv0), .dout_0(dout0),
      .req_1(req1), .we_1(we1), .dir_1(dir1), .din_1(din1),
      .gnt_1(gnt1), .rvalid_1(rv1), .dout_1(dout1),
      .mem_read(mrd), .mem_write(mwr), .mem_dir(mdir), .mem_din(mdin),
      .mem_dout(mdout)
   );

   arbitro_memoria #(.PRIORIDAD_FIJA(1), .MAX_ESPERA(3)) u_f (
      .clk(clk), .reset_n(reset_n),
      .req_0(req0_f), .we_0(1'b0), .dir_0(10'd1), .din_0(32'd0),
      .gnt_0(gnt0_f), .rvalid_0(rv0_f), .dout_0(dout0_f),
      .req_1(req1_f), .we_1(1'b0), .dir_1(10'd2), .din_1(32'd0),
      .gnt_1(gnt1_f), .rvalid_1(rv1_f), .dout_1(dout1_f),
      .mem_read(mrd_f), .mem_write(mwr_f), .mem_dir(mdir_f), .mem_din(mdin_f),
      .mem_dout(mdout_f)
   );

   always #5 clk = ~clk;

   // Memory models: act on the falling edge, zero-filled at the first edge.
   logic [31:0] mem_a [1024];
   logic [31:0] mem_f [1024];
   bit ready_a = 1'b0;
   bit ready_f = 1'b0;
   always @(negedge clk) begin
      if (!ready_a) begin
         for (int i = 0; i < 1024; i++) mem_a[i] <= '0;
         ready_a <= 1'b1;
      end else begin
         if (mwr) mem_a[mdir] <= mdin;
         if (mrd) mdout <= mem_a[mdir];
      end
   end
   always @(negedge clk) begin
      if (!ready_f) begin
         for (int i = 0; i < 1024; i++) mem_f[i] <= '0;
         ready_f <= 1'b1;
      end else begin
         if (mwr_f) mem_f[mdir_f] <= mdin_f;
         if (mrd_f) mdout_f <= mem_f[mdir_f];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      req0 = 1'b1; we0 = 1'b1; dir0 = 10'h3; din0 = 32'h1;
      step();
      step();
      n_cmp++; if ({gnt0, gnt1, rv0, rv1, mrd, mwr} !== 6'b0) begin
         n_err++; $display("FAIL reset_strobes: got %b want 000000", {gnt0, gnt1, rv0, rv1, mrd, mwr}); end
      n_cmp++; if ({dout0, dout1, mdin} !== 96'b0 || mdir !== 10'b0) begin
         n_err++; $display("FAIL reset_data: got %h/%h/%h/%h want zeros", dout0, dout1, mdin, mdir); end
      n_cmp++; if ({gnt0_f, gnt1_f, rv0_f, rv1_f, mrd_f, mwr_f} !== 6'b0) begin
         n_err++; $display("FAIL reset_f_strobes: got %b want 000000", {gnt0_f, gnt1_f, rv0_f, rv1_f, mrd_f, mwr_f}); end
      req0 = 1'b0; we0 = 1'b0;
      reset_n = 1'b1;
   endtask

   // Port 0 writes 0x005, port 1 reads it back (both request together).
   task automatic test_raw();
      req0 = 1; we0 = 1; dir0 = 10'h005; din0 = 32'hDEADBEEF;
      req1 = 1; we1 = 0; dir1 = 10'h005;
      step();
      n_cmp++; if ({gnt0, gnt1, mwr, mrd} !== 4'b1010 || mdir !== 10'h005 || mdin !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL raw_c1: got g0g1wr=%b dir=%h din=%h want 1010 005 deadbeef", {gnt0, gnt1, mwr, mrd}, mdir, mdin); end
      req0 = 0; we0 = 0;
      step();
      n_cmp++; if ({gnt0, gnt1, mwr, mrd, rv1} !== 5'b01010) begin
         n_err++; $display("FAIL raw_c2: got %b want 01010", {gnt0, gnt1, mwr, mrd, rv1}); end
      req1 = 0;
      step();
      n_cmp++; if ({gnt0, gnt1, mwr, mrd, rv0, rv1} !== 6'b000001 || dout1 !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL raw_c3: got %b dout1=%h want 000001 deadbeef", {gnt0, gnt1, mwr, mrd, rv0, rv1}, dout1); end
   endtask

   // Reset lands between the write grant and the memory falling edge.
   task automatic test_reset_mid();
      req0 = 1; we0 = 1; dir0 = 10'h3FF; din0 = 32'h12345678;
      step();
      n_cmp++; if ({gnt0, mwr} !== 2'b11) begin
         n_err++; $display("FAIL mid_grant: got %b want 11", {gnt0, mwr}); end
      #1 reset_n = 1'b0;
      req0 = 0; we0 = 0;
      #1;
      n_cmp++; if ({gnt0, mwr, mrd} !== 3'b000 || mdir !== 10'h0 || mdin !== 32'h0) begin
         n_err++; $display("FAIL mid_async: got %b dir=%h din=%h want 000 0 0", {gnt0, mwr, mrd}, mdir, mdin); end
      @(posedge clk);
      #1 reset_n = 1'b1;
      req0 = 1; we0 = 0; dir0 = 10'h3FF;
      n_cmp++; if ({rv0, rv1} !== 2'b00) begin
         n_err++; $display("FAIL mid_norv: got %b want 00", {rv0, rv1}); end
      step();
      n_cmp++; if ({gnt0, mrd, mwr, rv0} !== 4'b1100 || mdir !== 10'h3FF) begin
         n_err++; $display("FAIL mid_read_gnt: got %b dir=%h want 1100 3ff", {gnt0, mrd, mwr, rv0}, mdir); end
      req0 = 0;
      step();
      n_cmp++; if (rv0 !== 1'b1 || dout0 !== 32'h0) begin
         n_err++; $display("FAIL mid_readback: got rv=%b dout=%h want 1 00000000", rv0, dout0); end
   endtask

   // Address extremes with distinct data, then idle cycles keep dout.
   task automatic test_boundary();
      req1 = 1; we1 = 1; dir1 = 10'h000; din1 = 32'hA5A50001;
      step();
      n_cmp++; if ({gnt1, mwr} !== 2'b11 || mdir !== 10'h000) begin
         n_err++; $display("FAIL bnd_w0: got %b dir=%h want 11 000", {gnt1, mwr}, mdir); end
      req1 = 0; we1 = 0;
      req0 = 1; we0 = 1; dir0 = 10'h3FF; din0 = 32'h5A5A03FF;
      step();
      n_cmp++; if ({gnt0, gnt1, mwr} !== 3'b101 || mdir !== 10'h3FF) begin
         n_err++; $display("FAIL bnd_w3ff: got %b dir=%h want 101 3ff", {gnt0, gnt1, mwr}, mdir); end
      we0 = 0; dir0 = 10'h000;
      step();
      req0 = 0;
      req1 = 1; we1 = 0; dir1 = 10'h3FF;
      step();
      n_cmp++; if ({gnt1, rv0} !== 2'b11 || dout0 !== 32'hA5A50001) begin
         n_err++; $display("FAIL bnd_r0: got %b dout0=%h want 11 a5a50001", {gnt1, rv0}, dout0); end
      req1 = 0;
      step();
      n_cmp++; if (rv1 !== 1'b1 || dout1 !== 32'h5A5A03FF) begin
         n_err++; $display("FAIL bnd_r3ff: got rv1=%b dout1=%h want 1 5a5a03ff", rv1, dout1); end
      step();
      n_cmp++; if ({mrd, mwr, rv0, rv1} !== 4'b0000 || dout0 !== 32'hA5A50001 || dout1 !== 32'h5A5A03FF) begin
         n_err++; $display("FAIL idle_hold: got %b dout0=%h dout1=%h want 0000 a5a50001 5a5a03ff", {mrd, mwr, rv0, rv1}, dout0, dout1); end
   endtask

   // Round-robin with both ports reading continuously from reset.
   task automatic test_back_to_back();
      logic [3:0] e_g0, e_g1, e_rv0, e_rv1;
      e_g0 = 4'b0101; e_g1 = 4'b1010; e_rv0 = 4'b1010; e_rv1 = 4'b0100;
      pulse_reset();
      req0 = 1; we0 = 0; dir0 = 10'h000;
      req1 = 1; we1 = 0; dir1 = 10'h3FF;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if ({gnt0, gnt1, rv0, rv1} !== {e_g0[i], e_g1[i], e_rv0[i], e_rv1[i]} || (mrd & mwr)) begin
            n_err++; $display("FAIL rr_c%0d: got g0g1rv0rv1=%b want %b", i + 1, {gnt0, gnt1, rv0, rv1}, {e_g0[i], e_g1[i], e_rv0[i], e_rv1[i]}); end
      end
      n_cmp++; if (dout0 !== 32'hA5A50001 || dout1 !== 32'h5A5A03FF) begin
         n_err++; $display("FAIL rr_data: got %h/%h want a5a50001/5a5a03ff", dout0, dout1); end
      req0 = 0; req1 = 0;
      step();
      n_cmp++; if ({gnt0, gnt1, rv0, rv1, mrd} !== 5'b00010) begin
         n_err++; $display("FAIL rr_tail: got %b want 00010", {gnt0, gnt1, rv0, rv1, mrd}); end
   endtask

   // Fixed priority with MAX_ESPERA=3: port 1 forced every fourth tie.
   task automatic test_fixed();
      logic [7:0] e_g1;
      e_g1 = 8'b1000_1000;
      pulse_reset();
      req0_f = 1; req1_f = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_cmp++; if ({gnt0_f, gnt1_f} !== {~e_g1[i], e_g1[i]}) begin
            n_err++; $display("FAIL fix_c%0d: got g0g1=%b want %b", i + 1, {gnt0_f, gnt1_f}, {~e_g1[i], e_g1[i]}); end
         if (i == 4) begin
            n_cmp++; if ({rv0_f, rv1_f} !== 2'b01) begin
               n_err++; $display("FAIL fix_rv: got %b want 01", {rv0_f, rv1_f}); end
         end
      end
      req0_f = 0; req1_f = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_raw();
      test_reset_mid();
      test_boundary();
      test_back_to_back();
      test_fixed();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
